// File: rtl/nonogram_pkg.sv
// Shared types for the nonogram line/option datapath: widths, queue entry and FSM state.
package nonogram_pkg;

    localparam int unsigned MAX_ROWS  = 3;
    localparam int unsigned MAX_COLS  = 3;
    localparam int unsigned NUM_LINES = MAX_ROWS + MAX_COLS;
    localparam int unsigned OPT_W     = (MAX_ROWS > MAX_COLS) ? MAX_ROWS : MAX_COLS;
    localparam int unsigned CNT_W     = 7;
    localparam int unsigned LINE_W    = $clog2(NUM_LINES);

    typedef logic [OPT_W-1:0]  opt_t;
    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [LINE_W-1:0] line_idx_t;

    typedef struct packed {
        logic is_index;
        opt_t payload;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STREAM,
        DONE
    } state_t;

endpackage

// File: rtl/circ_fifo.sv
// Single-clock circular buffer: one push and one pop per cycle, head is a combinational read.
module circ_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_q, wr_q;
    logic [PTR_W:0]   cnt_q;
    logic             do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == FULL_CNT);
    assign count   = cnt_q;
    assign head    = mem[rd_q];
    assign do_pop  = pop && !empty;
    // A full queue still takes a push when the same cycle frees a slot.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            rd_q  <= wr_q;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_q] <= push_data;
    end

endmodule

// File: rtl/line_option_queue.sv
// Circular header/option store replaying lines round-robin to the solver and tracking
// per-line option counts, round boundaries and stuck/done status.
module line_option_queue
    import nonogram_pkg::*;
#(
    parameter int unsigned DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_valid,
    input  logic                       load_is_index,
    input  logic [OPT_W-1:0]           load_data,
    output logic                       load_ready,
    input  logic                       load_done,
    output logic [OPT_W-1:0]           option,
    output logic                       option_valid,
    output logic                       option_is_index,
    output logic                       started,
    input  logic                       put_back,
    input  logic                       solved,
    output logic [NUM_LINES*CNT_W-1:0] old_options_amnt,
    output logic                       round_done,
    output logic                       stuck,
    output logic                       overflow,
    output logic                       busy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam cnt_t      CNT_MAX   = '1;
    localparam line_idx_t LAST_LINE = line_idx_t'(NUM_LINES - 1);

    state_t         state_q, state_d;
    entry_t         head, hold_q, push_data, load_entry;
    logic           hold_valid_q, first_pop_q;
    logic           fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic [PTR_W:0] fifo_count;
    line_idx_t      load_line_q, stream_line_q;
    cnt_t           load_cnt_q [NUM_LINES];
    cnt_t           load_cnt_d [NUM_LINES];
    cnt_t           new_cnt_q  [NUM_LINES];
    cnt_t           old_cnt_q  [NUM_LINES];
    logic           load_accept, hold_push, boundary, counts_equal, ovf_set;

    circ_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (push_data),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign load_entry  = '{is_index: load_is_index, payload: load_data};
    assign load_ready  = ((state_q == IDLE) || (state_q == LOAD)) && !fifo_full;
    assign load_accept = load_valid && load_ready;
    assign busy        = (state_q == STREAM);
    assign hold_push   = hold_valid_q && (hold_q.is_index || put_back);
    // Header 0 in the hold slot marks a round edge, except on the very first pop.
    assign boundary    = hold_valid_q && hold_q.is_index && (hold_q.payload == '0) && !started;

    always_comb begin
        counts_equal = 1'b1;
        old_options_amnt = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (new_cnt_q[i] != old_cnt_q[i]) counts_equal = 1'b0;
            old_options_amnt[i*CNT_W +: CNT_W] = old_cnt_q[i];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_LINES; i++) load_cnt_d[i] = load_cnt_q[i];
        if (load_accept && !load_is_index && (load_line_q <= LAST_LINE) &&
            (load_cnt_q[load_line_q] != CNT_MAX)) begin
            load_cnt_d[load_line_q] = load_cnt_q[load_line_q] + 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;
        push_data  = load_entry;
        unique case (state_q)
            IDLE: begin
                if (load_accept) begin
                    fifo_push = 1'b1;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                fifo_push = load_accept;
                if (load_done) state_d = STREAM;
            end
            STREAM: begin
                if (solved) begin
                    fifo_flush = 1'b1;
                    state_d    = DONE;
                end else begin
                    fifo_pop  = !fifo_empty;
                    fifo_push = hold_push;
                    push_data = hold_q;
                    if (fifo_empty && !hold_push) state_d = DONE;
                end
            end
            DONE: state_d = DONE;
            default: state_d = IDLE;
        endcase
        ovf_set = (((state_q == IDLE) || (state_q == LOAD)) && load_valid &&
                   (fifo_count == FULL_CNT)) ||
                  ((state_q == STREAM) && fifo_push && fifo_full && !fifo_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            hold_valid_q    <= 1'b0;
            hold_q          <= '0;
            first_pop_q     <= 1'b0;
            option          <= '0;
            option_valid    <= 1'b0;
            option_is_index <= 1'b0;
            started         <= 1'b0;
            round_done      <= 1'b0;
            stuck           <= 1'b0;
            overflow        <= 1'b0;
            load_line_q     <= '0;
            stream_line_q   <= '0;
            for (int i = 0; i < NUM_LINES; i++) begin
                load_cnt_q[i] <= '0;
                new_cnt_q[i]  <= '0;
                old_cnt_q[i]  <= '0;
            end
        end else begin
            state_q      <= state_d;
            round_done   <= 1'b0;
            started      <= 1'b0;
            option_valid <= 1'b0;
            if (ovf_set) overflow <= 1'b1;
            for (int i = 0; i < NUM_LINES; i++) load_cnt_q[i] <= load_cnt_d[i];
            if (load_accept && load_is_index) load_line_q <= line_idx_t'(load_data);

            if ((state_q == LOAD) && load_done) begin
                first_pop_q <= 1'b1;
                for (int i = 0; i < NUM_LINES; i++) begin
                    old_cnt_q[i] <= load_cnt_d[i];
                    new_cnt_q[i] <= '0;
                end
            end

            if (state_q == STREAM) begin
                if (solved) begin
                    hold_valid_q <= 1'b0;
                end else begin
                    hold_valid_q <= fifo_pop;
                    if (fifo_pop) begin
                        hold_q          <= head;
                        option          <= head.payload;
                        option_is_index <= head.is_index;
                        option_valid    <= 1'b1;
                        started         <= first_pop_q;
                        first_pop_q     <= 1'b0;
                        if (head.is_index) stream_line_q <= line_idx_t'(head.payload);
                    end
                    // stream_line_q still names the held option's line on a header pop edge.
                    if (hold_push && !hold_q.is_index && (stream_line_q <= LAST_LINE) &&
                        (new_cnt_q[stream_line_q] != CNT_MAX)) begin
                        new_cnt_q[stream_line_q] <= new_cnt_q[stream_line_q] + 1'b1;
                    end
                    if (boundary) begin
                        round_done <= 1'b1;
                        if (counts_equal) stuck <= 1'b1;
                        for (int i = 0; i < NUM_LINES; i++) begin
                            old_cnt_q[i] <= new_cnt_q[i];
                            new_cnt_q[i] <= '0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_line_option_queue.sv
// Directed bench: 3x3 board load, two full rounds, stuck detection, solve, reset replay, overflow.
module tb_line_option_queue;
    import nonogram_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        load_valid = 0, load_is_index = 0, load_done = 0, put_back = 0, solved = 0;
    opt_t        load_data = '0;
    logic        load_ready, option_valid, option_is_index, started, round_done, stuck;
    logic        overflow, busy;
    opt_t        option;
    logic [41:0] old_amnt;

    logic        load_valid2 = 0, load_is_index2 = 0, load_done2 = 0;
    opt_t        load_data2 = '0;
    logic        load_ready2, option_valid2, option_is_index2, started2, round_done2, stuck2;
    logic        overflow2, busy2;
    opt_t        option2;
    logic [41:0] old_amnt2;

    int total = 0;
    int bad   = 0;

    line_option_queue #(.DEPTH(64)) u_dut (
        .clk (clk), .rst (rst),
        .load_valid (load_valid), .load_is_index (load_is_index), .load_data (load_data),
        .load_ready (load_ready), .load_done (load_done),
        .option (option), .option_valid (option_valid), .option_is_index (option_is_index),
        .started (started), .put_back (put_back), .solved (solved),
        .old_options_amnt (old_amnt), .round_done (round_done), .stuck (stuck),
        .overflow (overflow), .busy (busy)
    );

    line_option_queue #(.DEPTH(16)) u_dut2 (
        .clk (clk), .rst (rst),
        .load_valid (load_valid2), .load_is_index (load_is_index2), .load_data (load_data2),
        .load_ready (load_ready2), .load_done (load_done2),
        .option (option2), .option_valid (option_valid2), .option_is_index (option_is_index2),
        .started (started2), .put_back (1'b0), .solved (1'b0),
        .old_options_amnt (old_amnt2), .round_done (round_done2), .stuck (stuck2),
        .overflow (overflow2), .busy (busy2)
    );

    // {is_index, payload}
    logic [3:0] board [18] = '{4'h8, 4'h6, 4'h3, 4'h9, 4'h4, 4'h2, 4'h1, 4'hA, 4'h5,
                               4'hB, 4'h5, 4'hC, 4'h6, 4'h3, 4'hD, 4'h4, 4'h2, 4'h1};
    logic       pb1   [18] = '{0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0};
    logic [3:0] r2    [10] = '{4'h8, 4'h6, 4'h9, 4'h2, 4'hA, 4'hB, 4'hC, 4'h3, 4'hD, 4'h4};

    function automatic logic [41:0] pack(input int c5, c4, c3, c2, c1, c0);
        return {7'(c5), 7'(c4), 7'(c3), 7'(c2), 7'(c1), 7'(c0)};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic load_board();
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            load_valid    = 1'b1;
            load_is_index = board[i][3];
            load_data     = board[i][2:0];
        end
        @(negedge clk);
        load_valid = 1'b0;
        load_done  = 1'b1;
        @(negedge clk);
        load_done  = 1'b0;
    endtask

    task automatic present(input string tag, input logic [3:0] exp, input logic pb,
                           input logic exp_rd);
        @(negedge clk);
        check({tag, "_valid"}, option_valid, 1'b1);
        check({tag, "_word"}, {option_is_index, option}, exp);
        check({tag, "_rdone"}, round_done, exp_rd);
        put_back = pb;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_valid", option_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_amnt", old_amnt, 42'd0);
        check("rst_flags", {started, round_done, stuck, overflow}, 4'b0000);
        check("rst_ready", load_ready, 1'b1);

        @(negedge clk) load_done = 1'b1;
        @(negedge clk) load_done = 1'b0;
        check("idle_done_ignored", busy, 1'b0);

        load_board();
        check("load_amnt", old_amnt, pack(3, 2, 1, 1, 3, 2));
        check("load_busy", busy, 1'b1);
        check("load_novalid", option_valid, 1'b0);

        for (int i = 0; i < 18; i++) begin
            present("r1", board[i], pb1[i], 1'b0);
            if (i == 0) check("started_first", started, 1'b1);
            if (i == 1) check("started_second", started, 1'b0);
        end
        for (int i = 0; i < 10; i++) begin
            present("r2", r2[i], 1'b1, i == 1);
            if (i == 1) begin
                check("r2_amnt", old_amnt, pack(1, 1, 0, 0, 1, 1));
                check("r2_stuck", stuck, 1'b0);
            end
        end
        present("r3", 4'h8, 1'b1, 1'b0);
        present("r3", 4'h6, 1'b1, 1'b1);
        check("r3_amnt", old_amnt, pack(1, 1, 0, 0, 1, 1));
        check("r3_stuck", stuck, 1'b1);
        solved = 1'b1;
        @(negedge clk);
        solved   = 1'b0;
        put_back = 1'b0;
        check("solved_valid", option_valid, 1'b0);
        check("solved_busy", busy, 1'b0);
        check("solved_empty", u_dut.fifo_count, 0);
        check("solved_stuck", stuck, 1'b1);
        @(negedge clk);
        check("done_hold_valid", option_valid, 1'b0);
        check("done_hold_word", option, 3'b110);

        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        load_board();
        present("pre", 4'h8, 1'b0, 1'b0);
        present("pre", 4'h6, 1'b0, 1'b0);
        present("pre", 4'h3, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_valid", option_valid, 1'b0);
        check("mid_rst_word", {option_is_index, option}, 4'h0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_amnt", old_amnt, 42'd0);
        check("mid_rst_flags", {started, round_done, stuck, overflow}, 4'b0000);
        check("mid_rst_ready", load_ready, 1'b1);

        load_board();
        check("reload_amnt", old_amnt, pack(3, 2, 1, 1, 3, 2));
        present("reload", 4'h8, 1'b0, 1'b0);
        check("reload_started", started, 1'b1);
        present("reload", 4'h6, 1'b0, 1'b0);
        present("reload", 4'h3, 1'b0, 1'b0);

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            if (i == 16) begin
                check("ovf_ready_full", load_ready2, 1'b0);
                check("ovf_count_full", u_dut2.fifo_count, 16);
                check("ovf_pre_flag", overflow2, 1'b0);
            end
            load_valid2    = 1'b1;
            load_is_index2 = (i == 0);
            load_data2     = (i == 0) ? 3'b000 : 3'b001;
        end
        @(negedge clk);
        check("ovf_flag", overflow2, 1'b1);
        check("ovf_count_held", u_dut2.fifo_count, 16);
        load_valid2 = 1'b0;
        load_done2  = 1'b1;
        @(negedge clk);
        load_done2  = 1'b0;
        check("ovf_amnt", old_amnt2, pack(0, 0, 0, 0, 0, 15));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
